// File: rtl/inv_cipher_iter.sv
// rtl/inv_cipher_iter.sv - iterative AES-128 InvCipher, one round per clock
// Byte k of a 128-bit block is bits [8k +: 8]; bytes are column-major (k = row + 4*col).
module inv_cipher_iter #(
  parameter int NR = 10
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic [0:127]  in_i,
  input  logic [0:1407] words_i,
  output logic [0:127]  out_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [0:3]    round_o
);

  typedef enum logic [1:0] {IDLE, RUN, LAST} fsm_e;

  localparam logic [0:2047] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiples 9, b, d, e of each byte are built from the x2/x4/x8 xtime chain.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  fsm_e           fsm_q;
  logic [0:127]   blk_q;
  logic [0:1407]  key_q;
  logic [0:127]   out_q;
  logic           busy_q;
  logic           done_q;
  logic [0:3]     round_q;

  logic [0:127]   isb;
  logic [0:127]   rkey;
  logic [0:127]   ark;
  logic [0:127]   blk_d;

  // InvShiftRows (row r rotated right by r) folded into the InvSubBytes lookup.
  always_comb begin
    isb = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        isb[8*(r+4*c) +: 8] = inv_sbox(blk_q[8*(r+4*((c+4-r)%4)) +: 8]);
      end
    end
  end

  always_comb begin
    rkey = key_q[0 +: 128];
    for (int r = 0; r <= NR; r++) begin
      if (round_q == 4'(r)) rkey = key_q[128*r +: 128];
    end
  end

  assign ark = isb ^ rkey;

  always_comb begin
    blk_d = '0;
    for (int c = 0; c < 4; c++) begin
      blk_d[32*c +: 32] = inv_mix_col(ark[32*c +: 32]);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fsm_q   <= IDLE;
      blk_q   <= '0;
      key_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      round_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (start_i) begin
            key_q   <= words_i;
            blk_q   <= in_i ^ words_i[128*NR +: 128];
            round_q <= 4'(NR - 1);
            busy_q  <= 1'b1;
            fsm_q   <= RUN;
          end
        end
        RUN: begin
          blk_q   <= blk_d;
          round_q <= round_q - 4'd1;
          if (round_q == 4'd1) fsm_q <= LAST;
        end
        LAST: begin
          // round_q is 0 here, so ark already holds the key-0 whitened result.
          out_q   <= ark;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          round_q <= '0;
          fsm_q   <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          round_q <= '0;
          fsm_q   <= IDLE;
        end
      endcase
    end
  end

  assign out_o   = out_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign round_o = round_q;

endmodule
